// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  // Fetch stage control states; FAULT is left only through reset.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Byte address of instruction ROM word 0 and the PC reset value.
  localparam logic [31:0] PC_BASE_DEF = 32'h0040_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// ROM, registers the returned word toward decode with a valid/ready handshake,
// accepts PC redirects and latches a sticky fault on bad fetch addresses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          Nloc    = 512,
  parameter int          Dbits   = 32,
  parameter logic [31:0] PC_BASE = PC_BASE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_target,
  output logic [$clog2(Nloc)-1:0] rom_addr,
  input  logic [Dbits-1:0]        rom_instr,
  output logic [Dbits-1:0]        instr,
  output logic [31:0]             instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             pc,
  output logic                    fault,
  output logic [31:0]             fault_addr
);

  localparam int          AW     = $clog2(Nloc);
  localparam logic [31:0] NLOC_W = 32'(Nloc);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [Dbits-1:0]  instr_q, instr_d;
  logic [31:0]       ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       faddr_q, faddr_d;

  logic [31:0]       off;
  logic [31:0]       word_idx;
  logic              pc_ok;

  // Range test and ROM word address derived purely from the current PC.
  always_comb begin
    off      = pc_q - PC_BASE;
    word_idx = off >> 2;
    pc_ok    = (off[1:0] == 2'b00) && (word_idx < NLOC_W);
    rom_addr = word_idx[AW-1:0];
  end

  // Next-state, redirect and capture decisions in priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    faddr_d = faddr_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (enable) begin
          if (redirect_valid) begin
            valid_d = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
              state_d = FAULT;
              fault_d = 1'b1;
              faddr_d = redirect_target;
            end else begin
              pc_d = redirect_target;
            end
          end else if (!valid_q || instr_ready) begin
            if (!pc_ok) begin
              state_d = FAULT;
              fault_d = 1'b1;
              faddr_d = pc_q;
              valid_d = 1'b0;
            end else begin
              instr_d = rom_instr;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + 32'd4;
            end
          end
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = FAULT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // State, PC and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= PC_BASE;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a ROM model holding word i = A000_0000 + i.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [8:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        fault;
  logic [31:0] fault_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign rom_instr = 32'hA000_0000 + {23'd0, rom_addr};

  fetch_stage #(.Nloc(512), .Dbits(32), .PC_BASE(32'h0040_0000)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc(pc),
    .fault(fault),
    .fault_addr(fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_instr,
                           input logic [31:0] e_ipc, input logic e_valid,
                           input logic [31:0] e_pc);
    check({tag, ".instr"},    instr,               e_instr);
    check({tag, ".instr_pc"}, instr_pc,            e_ipc);
    check({tag, ".valid"},    {31'd0, instr_valid}, {31'd0, e_valid});
    check({tag, ".pc"},       pc,                  e_pc);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; redirect_valid = 1'b0;
    redirect_target = '0; instr_ready = 1'b1;
    #12;
    check_out("reset", 32'h0, 32'h0, 1'b0, 32'h0040_0000);
    check("reset.fault", {31'd0, fault}, 32'd0);
    check("reset.fault_addr", fault_addr, 32'h0);
    check("reset.rom_addr", {23'd0, rom_addr}, 32'd0);

    step(); reset = 1'b0;
    step();
    check_out("boot", 32'h0, 32'h0, 1'b0, 32'h0040_0000);
    step(); check_out("seq0", 32'hA000_0000, 32'h0040_0000, 1'b1, 32'h0040_0004);
    step(); check_out("seq1", 32'hA000_0001, 32'h0040_0004, 1'b1, 32'h0040_0008);
    step(); check_out("seq2", 32'hA000_0002, 32'h0040_0008, 1'b1, 32'h0040_000C);

    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall", 32'hA000_0002, 32'h0040_0008, 1'b1, 32'h0040_000C);
    end
    instr_ready = 1'b1;
    step(); check_out("resume3", 32'hA000_0003, 32'h0040_000C, 1'b1, 32'h0040_0010);
    step(); check_out("resume4", 32'hA000_0004, 32'h0040_0010, 1'b1, 32'h0040_0014);

    redirect_valid = 1'b1; redirect_target = 32'h0040_0040;
    step(); redirect_valid = 1'b0;
    check("redir.bubble", {31'd0, instr_valid}, 32'd0);
    check("redir.pc", pc, 32'h0040_0040);
    step(); check_out("redir.first", 32'hA000_0010, 32'h0040_0040, 1'b1, 32'h0040_0044);

    enable = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0080;
    step(); check_out("freeze1", 32'hA000_0010, 32'h0040_0040, 1'b1, 32'h0040_0044);
    step(); check_out("freeze2", 32'hA000_0010, 32'h0040_0040, 1'b1, 32'h0040_0044);
    enable = 1'b1; redirect_valid = 1'b0;
    step(); check_out("unfreeze", 32'hA000_0011, 32'h0040_0044, 1'b1, 32'h0040_0048);

    redirect_valid = 1'b1; redirect_target = 32'h0040_07F8;
    step(); redirect_valid = 1'b0;
    check("tail.pc", pc, 32'h0040_07F8);
    step(); check_out("tail510", 32'hA000_01FE, 32'h0040_07F8, 1'b1, 32'h0040_07FC);
    step(); check_out("tail511", 32'hA000_01FF, 32'h0040_07FC, 1'b1, 32'h0040_0800);
    check("tail.rom_addr", {23'd0, rom_addr}, 32'd0);
    check("tail.nofault", {31'd0, fault}, 32'd0);
    step();
    check("range.fault", {31'd0, fault}, 32'd1);
    check("range.fault_addr", fault_addr, 32'h0040_0800);
    check("range.valid", {31'd0, instr_valid}, 32'd0);
    check("range.pc", pc, 32'h0040_0800);

    #3 reset = 1'b1;
    #1;
    check("areset1.fault", {31'd0, fault}, 32'd0);
    check("areset1.pc", pc, 32'h0040_0000);
    step(); reset = 1'b0;
    step(); check("boot2.valid", {31'd0, instr_valid}, 32'd0);
    step(); check_out("restart0", 32'hA000_0000, 32'h0040_0000, 1'b1, 32'h0040_0004);

    redirect_valid = 1'b1; redirect_target = 32'h0040_0042;
    step();
    check("mis.fault", {31'd0, fault}, 32'd1);
    check("mis.fault_addr", fault_addr, 32'h0040_0042);
    check("mis.valid", {31'd0, instr_valid}, 32'd0);
    check("mis.pc", pc, 32'h0040_0004);
    redirect_target = 32'h0040_0040;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sticky.fault", {31'd0, fault}, 32'd1);
      check("sticky.valid", {31'd0, instr_valid}, 32'd0);
      check("sticky.pc", pc, 32'h0040_0004);
      check("sticky.fault_addr", fault_addr, 32'h0040_0042);
    end
    check("sticky.rom_addr", {23'd0, rom_addr}, 32'd1);
    redirect_valid = 1'b0;

    #3 reset = 1'b1;
    #1;
    check("areset2.fault", {31'd0, fault}, 32'd0);
    check("areset2.fault_addr", fault_addr, 32'h0);
    check("areset2.pc", pc, 32'h0040_0000);
    step(); reset = 1'b0;
    step(); step();
    check_out("restart1", 32'hA000_0000, 32'h0040_0000, 1'b1, 32'h0040_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
